// File: rtl/hci_router_split.sv
// hci_router_split: maps one wide initiator onto NB_LANES adjacent banks (wrapping) and
// tolerates staggered bank grants. Optional macro HCI_ROUTER_SPARSE_EN skips zero-be lanes.
module hci_router_split #(
  parameter int unsigned DW_BANK     = 32,
  parameter int unsigned NB_LANES    = 4,
  parameter int unsigned NB_OUT_CHAN = 8,
  parameter int unsigned AW_BANK     = 10,
  localparam int unsigned DW_IN = NB_LANES * DW_BANK,
  localparam int unsigned BW    = DW_BANK / 8,
  localparam int unsigned OFFS  = $clog2(BW),
  localparam int unsigned IDXW  = $clog2(NB_OUT_CHAN),
  localparam int unsigned AW_IN = AW_BANK + IDXW + OFFS
) (
  input  logic                           clk_i,
  input  logic                           rst_ni,
  input  logic                           clear_i,
  input  logic                           in_req_i,
  output logic                           in_gnt_o,
  input  logic [AW_IN-1:0]               in_add_i,
  input  logic                           in_wen_i,
  input  logic [DW_IN/8-1:0]             in_be_i,
  input  logic [DW_IN-1:0]               in_data_i,
  output logic                           in_r_valid_o,
  input  logic                           in_r_ready_i,
  output logic [DW_IN-1:0]               in_r_data_o,
  output logic [NB_OUT_CHAN-1:0]         out_req_o,
  input  logic [NB_OUT_CHAN-1:0]         out_gnt_i,
  output logic [NB_OUT_CHAN*AW_BANK-1:0] out_add_o,
  output logic [NB_OUT_CHAN-1:0]         out_wen_o,
  output logic [NB_OUT_CHAN*BW-1:0]      out_be_o,
  output logic [NB_OUT_CHAN*DW_BANK-1:0] out_data_o,
  input  logic [NB_OUT_CHAN-1:0]         out_r_valid_i,
  input  logic [NB_OUT_CHAN*DW_BANK-1:0] out_r_data_i
);

  typedef enum logic [1:0] {IDLE, ISSUE, RESP} state_e;
  state_e r_state, w_state_next;

  logic [IDXW-1:0]        w_idx, r_idx;
  logic [AW_BANK-1:0]     w_row;
  logic [NB_OUT_CHAN-1:0] w_lane_act, w_bank_act, w_gnt_now, w_req, w_arrive;
  logic [NB_OUT_CHAN-1:0] r_gnt, r_pend, r_capt, r_act;
  logic [IDXW-1:0]        w_lane_of    [NB_OUT_CHAN];
  logic [DW_BANK-1:0]     w_lane_data  [NB_OUT_CHAN];
  logic [BW-1:0]          w_lane_be    [NB_OUT_CHAN];
  logic [DW_BANK-1:0]     w_bank_rdata [NB_OUT_CHAN];
  logic [DW_BANK-1:0]     r_buf        [NB_OUT_CHAN];
  logic                   r_wen;
  logic                   w_issuing, w_full, w_start, w_rvalid, w_resp_done;

  if (NB_LANES > NB_OUT_CHAN || NB_OUT_CHAN < 2 || DW_BANK < 8 ||
      (NB_LANES & (NB_LANES - 1)) != 0 || (NB_OUT_CHAN & (NB_OUT_CHAN - 1)) != 0 ||
      (DW_BANK & (DW_BANK - 1)) != 0) begin : g_param_err
    $error("hci_router_split: illegal parameter combination");
  end

  if (OFFS > 0) begin : g_offs
    logic w_unused_offs;
    assign w_unused_offs = ^in_add_i[OFFS-1:0];
  end

  assign w_idx = in_add_i[OFFS +: IDXW];
  assign w_row = in_add_i[OFFS+IDXW +: AW_BANK];

  // Lane views padded to NB_OUT_CHAN entries so unmapped banks see an inactive, zero lane.
  for (genvar gi = 0; gi < NB_OUT_CHAN; gi++) begin : g_lane
    if (gi < NB_LANES) begin : g_used
      assign w_lane_data[gi] = in_data_i[gi*DW_BANK +: DW_BANK];
      assign w_lane_be[gi]   = in_be_i[gi*BW +: BW];
`ifdef HCI_ROUTER_SPARSE_EN
      assign w_lane_act[gi]  = |in_be_i[gi*BW +: BW];
`else
      assign w_lane_act[gi]  = 1'b1;
`endif
    end else begin : g_pad
      assign w_lane_data[gi] = '0;
      assign w_lane_be[gi]   = '0;
      assign w_lane_act[gi]  = 1'b0;
    end
  end

  for (genvar gi = 0; gi < NB_OUT_CHAN; gi++) begin : g_bank
    assign w_lane_of[gi]  = IDXW'(gi) - w_idx;
    assign w_bank_act[gi] = w_lane_act[w_lane_of[gi]];
    assign w_req[gi]      = w_issuing & w_bank_act[gi] & ~r_gnt[gi];
    // A bank below idx is reached only by wrapping, so it serves the next row.
    assign out_add_o[gi*AW_BANK +: AW_BANK] =
      w_req[gi] ? w_row + AW_BANK'(IDXW'(gi) < w_idx) : '0;
    assign out_wen_o[gi] = w_req[gi] & in_wen_i;
    assign out_be_o[gi*BW +: BW] = w_req[gi] ? w_lane_be[w_lane_of[gi]] : '0;
    assign out_data_o[gi*DW_BANK +: DW_BANK] = w_req[gi] ? w_lane_data[w_lane_of[gi]] : '0;
    assign w_bank_rdata[gi] = r_capt[gi] ? r_buf[gi] : out_r_data_i[gi*DW_BANK +: DW_BANK];
  end

  assign out_req_o   = w_req;
  assign w_gnt_now   = r_gnt | (w_bank_act & out_gnt_i);
  assign w_full      = &(w_gnt_now | ~w_bank_act);
  assign w_arrive    = r_pend & out_r_valid_i;
  assign w_rvalid    = ~clear_i & (r_state == RESP) & (&(r_capt | w_arrive | ~r_act));
  assign w_resp_done = w_rvalid & in_r_ready_i;
  assign w_issuing   = in_req_i & ~clear_i & ((r_state != RESP) | w_resp_done);
  assign w_start     = w_issuing & (r_state != ISSUE);

  for (genvar gi = 0; gi < NB_LANES; gi++) begin : g_rdata
    logic [IDXW-1:0] w_bank;
    assign w_bank = r_idx + IDXW'(gi);
    assign in_r_data_o[gi*DW_BANK +: DW_BANK] =
      (w_rvalid & r_wen & r_act[w_bank]) ? w_bank_rdata[w_bank] : '0;
  end

  always_comb begin
    w_state_next = r_state;
    in_gnt_o     = w_issuing & w_full;
    in_r_valid_o = w_rvalid;
    case (r_state)
      IDLE, RESP: begin
        if (w_issuing)        w_state_next = w_full ? RESP : ISSUE;
        else if (w_resp_done) w_state_next = IDLE;
      end
      ISSUE:   if (w_issuing && w_full) w_state_next = RESP;
      default: w_state_next = IDLE;
    endcase
    if (clear_i) w_state_next = IDLE;
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      r_state <= IDLE;
      r_gnt   <= '0;
      r_pend  <= '0;
      r_capt  <= '0;
      r_act   <= '0;
      r_idx   <= '0;
      r_wen   <= 1'b0;
    end else if (clear_i) begin
      r_state <= IDLE;
      r_gnt   <= '0;
      r_pend  <= '0;
      r_capt  <= '0;
      r_act   <= '0;
      r_idx   <= '0;
      r_wen   <= 1'b0;
    end else begin
      r_state <= w_state_next;
      r_pend  <= w_req & out_gnt_i;
      // Arrivals on a start cycle belong to the access just drained.
      r_capt  <= w_start ? '0 : (r_capt | w_arrive);
      if (w_issuing) begin
        r_gnt <= w_full ? '0 : w_gnt_now;
        r_idx <= w_idx;
        r_act <= w_bank_act;
        r_wen <= in_wen_i;
      end
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      for (int i = 0; i < NB_OUT_CHAN; i++) r_buf[i] <= '0;
    end else begin
      for (int i = 0; i < NB_OUT_CHAN; i++)
        if (w_arrive[i]) r_buf[i] <= out_r_data_i[i*DW_BANK +: DW_BANK];
    end
  end

endmodule
